// File: rtl/vid_sync_ctrl_pkg.sv
// vid_ctrl_pkg: shared types and constants for the video sync controller.
//   vs_state_e : lock state machine encoding
//   XW_DEF/YW_DEF : default coordinate widths
//   CNT_W : width of the frame match counter
package vid_ctrl_pkg;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      MEASURE = 2'd1,
      VERIFY  = 2'd2,
      LOCKED  = 2'd3
   } vs_state_e;

   localparam int XW_DEF = 12;
   localparam int YW_DEF = 11;
   localparam int CNT_W  = 4;

endpackage

// File: rtl/vid_sync_ctrl_sync_edge_det.sv
// sync_edge_det: two-stage sampler for vde/hsync/vsync with edge pulses.
//   clk, rst      : pixel clock, async active-high reset
//   vde_i, hsync_i, vsync_i : raw sync inputs (vsync polarity set by VS_POL)
//   vde_o         : stage-1 vde level
//   hs_o          : stage-2 hsync level
//   vde_rise_o/vde_fall_o/vs_rise_o : edges between stage 1 and stage 2
// vsync is normalised to active-high before sampling.
module sync_edge_det #(
   parameter int VS_POL = 1
)(
   input  logic clk,
   input  logic rst,
   input  logic vde_i,
   input  logic hsync_i,
   input  logic vsync_i,
   output logic vde_o,
   output logic hs_o,
   output logic vde_rise_o,
   output logic vde_fall_o,
   output logic vs_rise_o
);

   logic vs_n;
   logic vde_s1_q, vde_s2_q, hs_s1_q, hs_s2_q, vs_s1_q, vs_s2_q;

   assign vs_n = (VS_POL != 0) ? vsync_i : ~vsync_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vde_s1_q <= 1'b0;
         vde_s2_q <= 1'b0;
         hs_s1_q  <= 1'b0;
         hs_s2_q  <= 1'b0;
         vs_s1_q  <= 1'b0;
         vs_s2_q  <= 1'b0;
      end else begin
         vde_s1_q <= vde_i;
         vde_s2_q <= vde_s1_q;
         hs_s1_q  <= hsync_i;
         hs_s2_q  <= hs_s1_q;
         vs_s1_q  <= vs_n;
         vs_s2_q  <= vs_s1_q;
      end
   end

   assign vde_o      = vde_s1_q;
   assign hs_o       = hs_s2_q;
   assign vde_rise_o = vde_s1_q & ~vde_s2_q;
   assign vde_fall_o = ~vde_s1_q & vde_s2_q;
   assign vs_rise_o  = vs_s1_q & ~vs_s2_q;

endmodule

// File: rtl/vid_sync_ctrl.sv
// vid_sync_ctrl: pixel-domain sync tracker, resolution measurement and lock.
//   clk, rst        : pixel clock, async active-high reset
//   vde_i/hsync_i/vsync_i : incoming video timing
//   en_i            : processing enable request
//   pix_valid_o, x_o, y_o : pixel qualifier and coordinates (2-cycle latency)
//   line_start_o, frame_start_o : 1-cycle strobes
//   h_active_o, v_active_o : captured resolution
//   locked_o, proc_en_o : lock status and frame-aligned processing enable
//   wdog_o          : watchdog expiry pulse
// Optional watchdog built only when VID_SYNC_WDOG_EN is defined.
module vid_sync_ctrl
   import vid_ctrl_pkg::*;
#(
   parameter int XW          = XW_DEF,
   parameter int YW          = YW_DEF,
   parameter int LOCK_FRAMES = 2,
   parameter int VS_POL      = 1,
   parameter int WDOG_CYCLES = 2000000
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          vde_i,
   input  logic          hsync_i,
   input  logic          vsync_i,
   input  logic          en_i,
   output logic          pix_valid_o,
   output logic [XW-1:0] x_o,
   output logic [YW-1:0] y_o,
   output logic          line_start_o,
   output logic          frame_start_o,
   output logic [XW-1:0] h_active_o,
   output logic [YW-1:0] v_active_o,
   output logic          locked_o,
   output logic          proc_en_o,
   output logic          wdog_o
);

   localparam logic [CNT_W-1:0] LOCK_N = CNT_W'(LOCK_FRAMES);

   logic vde_s1, vde_rise, vde_fall, vs_rise, hs_lvl, unused_hs;
   logic en_s1_q, pix_valid_q, line_start_q, frame_start_q, locked_q, wdog_q;
   logic proc_en_q, proc_en_d, wd_hit;
   logic first_q, first_d, dirty_q, dirty_d;
   logic [XW-1:0] x_q, x_d, meas_w_q, meas_w_d, h_act_q, h_act_d;
   logic [XW-1:0] w, ref_w, meas_w_eff;
   logic [YW-1:0] y_q, y_d, y_inc, height, v_act_q, v_act_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic ovf, cap_first, line_bad;
   vs_state_e state_q, state_d;

   sync_edge_det #(.VS_POL(VS_POL)) u_edge (
      .clk(clk), .rst(rst), .vde_i(vde_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
      .vde_o(vde_s1), .hs_o(hs_lvl), .vde_rise_o(vde_rise), .vde_fall_o(vde_fall),
      .vs_rise_o(vs_rise)
   );

   // hsync is sampled for alignment only; nothing counts on it.
   assign unused_hs = hs_lvl;

   // Line width is x+1; x stuck at all-ones means the width cannot be represented.
   assign ovf        = (x_q == '1);
   assign w          = x_q + 1'b1;
   assign y_inc      = (y_q == '1) ? y_q : y_q + 1'b1;
   // A line ending in the vsync cycle belongs to the frame that is closing.
   assign height     = vde_fall ? y_inc : y_q;
   assign cap_first  = (state_q == MEASURE) && first_q;
   assign ref_w      = (state_q == MEASURE) ? meas_w_q : h_act_q;
   assign line_bad   = vde_fall && (ovf || (!cap_first && (w != ref_w)));
   assign meas_w_eff = (vde_fall && cap_first) ? w : meas_w_q;
   assign cnt_inc    = cnt_q + 1'b1;

   always_comb begin
      x_d = x_q;
      if (vde_s1) x_d = vde_rise ? '0 : (ovf ? x_q : x_q + 1'b1);
      y_d = vs_rise ? '0 : (vde_fall ? y_inc : y_q);
   end

`ifdef VID_SYNC_WDOG_EN
   localparam int WDW = $clog2(WDOG_CYCLES + 1);
   localparam logic [WDW-1:0] WD_MAX = WDW'(WDOG_CYCLES);
   logic [WDW-1:0] wd_q, wd_d;

   // Counter parks at WD_MAX until the next frame so only one pulse fires.
   always_comb begin
      wd_d   = wd_q;
      wd_hit = 1'b0;
      if (vs_rise) begin
         wd_d = '0;
      end else if (wd_q != WD_MAX) begin
         wd_d   = wd_q + 1'b1;
         wd_hit = (wd_d == WD_MAX);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) wd_q <= '0;
      else     wd_q <= wd_d;
   end
`else
   localparam int unused_wdog_cycles = WDOG_CYCLES;
   assign wd_hit = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      first_d  = first_q;
      dirty_d  = dirty_q;
      meas_w_d = meas_w_q;
      h_act_d  = h_act_q;
      v_act_d  = v_act_q;
      cnt_d    = cnt_q;
      case (state_q)
         SEARCH: begin
            if (vs_rise) begin
               state_d = MEASURE;
               first_d = 1'b1;
               dirty_d = 1'b0;
            end
         end
         MEASURE: begin
            if (vde_fall) begin
               if (first_q) begin
                  meas_w_d = w;
                  first_d  = 1'b0;
               end
               if (line_bad) dirty_d = 1'b1;
            end
            if (vs_rise) begin
               first_d = 1'b1;
               dirty_d = 1'b0;
               if (!dirty_q && !line_bad && (height != '0)) begin
                  state_d = VERIFY;
                  h_act_d = meas_w_eff;
                  v_act_d = height;
                  cnt_d   = CNT_W'(1);
               end
            end
         end
         VERIFY, LOCKED: begin
            if (vs_rise) begin
               first_d = 1'b1;
               dirty_d = 1'b0;
               if (!line_bad && (height == v_act_q) && (height != '0)) begin
                  if (state_q == VERIFY) begin
                     cnt_d = cnt_inc;
                     if (cnt_inc >= LOCK_N) state_d = LOCKED;
                  end
               end else begin
                  state_d = MEASURE;
               end
            end else if (line_bad) begin
               // Mid-frame drop: mark dirty so the partial frame is never captured.
               state_d = MEASURE;
               first_d = 1'b1;
               dirty_d = 1'b1;
            end
         end
         default: state_d = SEARCH;
      endcase
      if (wd_hit) state_d = SEARCH;
   end

   // Enable samples the request only on the frame strobe; any lock loss clears it at once.
   always_comb begin
      proc_en_d = proc_en_q;
      if (frame_start_q) proc_en_d = locked_q & en_s1_q;
      if (state_d != LOCKED) proc_en_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= SEARCH;
         first_q       <= 1'b1;
         dirty_q       <= 1'b0;
         meas_w_q      <= '0;
         h_act_q       <= '0;
         v_act_q       <= '0;
         cnt_q         <= '0;
         x_q           <= '0;
         y_q           <= '0;
         en_s1_q       <= 1'b0;
         pix_valid_q   <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         locked_q      <= 1'b0;
         proc_en_q     <= 1'b0;
         wdog_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         first_q       <= first_d;
         dirty_q       <= dirty_d;
         meas_w_q      <= meas_w_d;
         h_act_q       <= h_act_d;
         v_act_q       <= v_act_d;
         cnt_q         <= cnt_d;
         x_q           <= x_d;
         y_q           <= y_d;
         en_s1_q       <= en_i;
         pix_valid_q   <= vde_s1;
         line_start_q  <= vde_rise;
         frame_start_q <= vs_rise;
         locked_q      <= (state_d == LOCKED);
         proc_en_q     <= proc_en_d;
         wdog_q        <= wd_hit;
      end
   end

   assign pix_valid_o   = pix_valid_q;
   assign x_o           = x_q;
   assign y_o           = y_q;
   assign line_start_o  = line_start_q;
   assign frame_start_o = frame_start_q;
   assign h_active_o    = h_act_q;
   assign v_active_o    = v_act_q;
   assign locked_o      = locked_q;
   assign proc_en_o     = proc_en_q;
   assign wdog_o        = wdog_q;

endmodule

// File: tb/tb_vid_sync_ctrl.sv
// tb_vid_sync_ctrl: scoreboard bench for vid_sync_ctrl. Pixel coordinates are
// queued when vde is driven and compared when pix_valid_o appears.
module tb_vid_sync_ctrl;
   localparam int XW = 12;
   localparam int YW = 11;
   localparam int WD = 100;

   logic clk, rst, vde_i, hsync_i, vsync_i, en_i;
   logic pix_valid_o, line_start_o, frame_start_o, locked_o, proc_en_o, wdog_o;
   logic [XW-1:0] x_o, h_active_o;
   logic [YW-1:0] y_o, v_active_o;

   vid_sync_ctrl #(.XW(XW), .YW(YW), .LOCK_FRAMES(2), .VS_POL(1), .WDOG_CYCLES(WD)) dut (
      .clk(clk), .rst(rst), .vde_i(vde_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
      .en_i(en_i), .pix_valid_o(pix_valid_o), .x_o(x_o), .y_o(y_o),
      .line_start_o(line_start_o), .frame_start_o(frame_start_o),
      .h_active_o(h_active_o), .v_active_o(v_active_o), .locked_o(locked_o),
      .proc_en_o(proc_en_o), .wdog_o(wdog_o)
   );

   typedef struct { int x; int y; int c; } exp_t;
   exp_t sb[$];
   exp_t mon_e;
   int total = 0, bad = 0, cyc = 0, ym = 0, wd_pulses = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      vde_i = 1'b0;
      repeat (n) tick;
   endtask

   task automatic vs;
      vde_i   = 1'b0;
      vsync_i = 1'b1;
      ym      = 0;
      tick;
      tick;
      chk("frame_start", frame_start_o, 1);
      tick;
      vsync_i = 1'b0;
   endtask

   task automatic line(input int w, input int gap);
      for (int i = 0; i < w; i++) begin
         vde_i = 1'b1;
         sb.push_back('{x: (i > 4095) ? 4095 : i, y: ym, c: cyc});
         tick;
         if (i == 1) chk("line_start", line_start_o, 1);
      end
      vde_i = 1'b0;
      ym++;
      repeat (gap) tick;
   endtask

   task automatic frame(input int w, input int h, input int bad_l, input int bad_w, input bit tight);
      vs();
      idle(2);
      for (int l = 0; l < h; l++)
         line((l == bad_l) ? bad_w : w, (tight && l == h - 1) ? 0 : 4);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (wdog_o) wd_pulses++;
         if (pix_valid_o) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", sb.size(), 1);
            end else begin
               mon_e = sb.pop_front();
               chk("x", x_o, mon_e.x);
               chk("y", y_o, mon_e.y);
               chk("latency", cyc - mon_e.c, 2);
            end
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; vde_i = 1'b0; hsync_i = 1'b0; vsync_i = 1'b0; en_i = 1'b0;
      repeat (3) tick;
      chk("rst_pix_valid", pix_valid_o, 0);
      chk("rst_x", x_o, 0);
      chk("rst_y", y_o, 0);
      chk("rst_line_start", line_start_o, 0);
      chk("rst_frame_start", frame_start_o, 0);
      chk("rst_h_active", h_active_o, 0);
      chk("rst_v_active", v_active_o, 0);
      chk("rst_locked", locked_o, 0);
      chk("rst_proc_en", proc_en_o, 0);
      chk("rst_wdog", wdog_o, 0);
      rst = 1'b0;
      idle(3);

      // Basic lock on 8x4.
      frame(8, 4, -1, 0, 0);
      frame(8, 4, -1, 0, 0);
      chk("lock_early", locked_o, 0);
      frame(8, 4, -1, 0, 0);
      chk("lock_3rd", locked_o, 1);
      chk("h_active", h_active_o, 8);
      chk("v_active", v_active_o, 4);
      chk("proc_en_no_req", proc_en_o, 0);

      // Enable request mid-frame waits for the next frame start.
      en_i = 1'b1;
      idle(3);
      chk("proc_en_midframe", proc_en_o, 0);
      frame(8, 4, -1, 0, 0);
      chk("proc_en_next_frame", proc_en_o, 1);

      // Short line drops lock, then relock after clean frames.
      frame(8, 4, 1, 7, 0);
      chk("badline_locked", locked_o, 0);
      chk("badline_proc_en", proc_en_o, 0);
      frame(8, 4, -1, 0, 0);
      frame(8, 4, -1, 0, 0);
      chk("relock_early", locked_o, 0);
      frame(8, 4, -1, 0, 0);
      chk("relock", locked_o, 1);
      chk("relock_proc_en", proc_en_o, 1);

      // Line end coincident with vsync edge counts toward the closing frame.
      frame(8, 4, -1, 0, 1);
      frame(8, 4, -1, 0, 0);
      chk("coincide_locked", locked_o, 1);
      chk("coincide_v_active", v_active_o, 4);
      chk("coincide_h_active", h_active_o, 8);

`ifdef VID_SYNC_WDOG_EN
      wd_pulses = 0;
      idle(WD + 20);
      chk("wdog_pulses", wd_pulses, 1);
      chk("wdog_locked", locked_o, 0);
      chk("wdog_proc_en", proc_en_o, 0);
      frame(8, 4, -1, 0, 0);
      frame(8, 4, -1, 0, 0);
      frame(8, 4, -1, 0, 0);
      chk("wdog_relock", locked_o, 1);
`endif

      // Reset, then frames with no active lines.
      idle(6);
      chk("sb_empty_pre_rst", sb.size(), 0);
      rst = 1'b1;
      tick;
      tick;
      chk("rst2_locked", locked_o, 0);
      chk("rst2_h_active", h_active_o, 0);
      rst = 1'b0;
      idle(2);
      repeat (4) begin
         vs();
         idle(10);
      end
      chk("zero_lines_locked", locked_o, 0);

      // 4096-pixel lines overflow x and must never lock.
      repeat (4) frame(4096, 1, -1, 0, 0);
      chk("ovf_locked", locked_o, 0);
      chk("ovf_x_sat", x_o, 4095);

      idle(6);
      chk("sb_empty_end", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
